led_blink_ctrl: RTL
===================

LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of button/LED channels (1..8).
REQ-002 SHALL have parameter SLOW_HALF, default 5000000, clk cycles per slow-phase half period (>=1).
REQ-003 SHALL have parameter FAST_HALF, default 500000, clk cycles per fast-phase half period (>=1).
REQ-004 SHALL have parameter DEBOUNCE, default 100000, consecutive stable clk cycles needed to accept a button change (>=2).
REQ-005 SHALL have parameter ALT_PHASE, default 1; when 1, odd channels blink in antiphase to even channels.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 nRst  input  1  reset, asynchronous, active-low.
REQ-008 nPB  input  CHANNELS  pushbuttons, active-low, asynchronous to clk, bouncing.
REQ-009 nLED  output  CHANNELS  LED drives, active-low, registered.
REQ-010 dbg  output  1  registered OR of all debounced pressed states.

Function
REQ-011 Shared slow divider: counter 0..SLOW_HALF-1; slow_ph toggles on the edge where counter is SLOW_HALF-1, counter wraps to 0.
REQ-012 Shared fast divider: identical to REQ-011 with FAST_HALF, producing fast_ph.
REQ-013 Each nPB bit SHALL pass a 2-flop synchronizer; sync value 1 = pressed (inverted nPB).
REQ-014 Per-channel debouncer: state db (1 = pressed), counter cnt; sync==db -> cnt=0; sync!=db -> cnt increments; on the edge where cnt==DEBOUNCE-1 and sync!=db, db flips and cnt=0.
REQ-015 Glitch shorter than DEBOUNCE cycles SHALL return cnt to 0 and leave db unchanged.
REQ-016 Press event = db 0->1 transition; release events SHALL have no effect on mode.
REQ-017 Per-channel mode FSM, states SLOW -> FAST -> ON -> OFF -> SLOW; advances one state per press event, registered one edge after db rises; OFF wraps to SLOW.
REQ-018 Channel phase p = slow_ph XOR (ALT_PHASE AND channel index odd) in SLOW; fast_ph XOR same term in FAST.
REQ-019 LED lit: SLOW/FAST -> p; ON -> 1; OFF -> 0; nLED = NOT lit, registered one edge after mode/phase.
REQ-020 Press-to-nLED latency SHALL be exactly DEBOUNCE+4 clk edges from first clk edge sampling nPB low (2 sync, DEBOUNCE debounce, 1 FSM, 1 output).
REQ-021 Channels SHALL be fully independent; simultaneous presses on several channels each advance their own FSM in the same cycle.
REQ-022 Divider wrap and press events coinciding SHALL both take effect in that cycle, neither lost.
REQ-023 Button held indefinitely SHALL produce exactly one press event.
REQ-024 dbg SHALL equal OR of all db, one edge later.

Reset
REQ-025 nRst low SHALL immediately force: divider counters 0, slow_ph 0, fast_ph 0, sync flops 0, db 0, cnt 0, mode SLOW, nLED all 1, dbg 0.
REQ-026 After nRst rises, first slow_ph toggle SHALL occur on the SLOW_HALF-th clk edge.
REQ-027 Reset asserted mid-debounce or mid-press SHALL discard that press; button still held at release of reset SHALL be accepted as a new press after DEBOUNCE+2 edges.

Verification (CHANNELS=2, SLOW_HALF=8, FAST_HALF=2, DEBOUNCE=4, ALT_PHASE=1)
REQ-028 Reset release, no buttons -> nLED[0] low for edges 9..16, high 17..24 repeating; nLED[1] exact complement.
REQ-029 nPB[0] held low from edge 0 -> mode FAST on edge 7, nLED[0] toggles every 2 edges from edge 8; nLED[1] unaffected.
REQ-030 nPB[0] pulses low 3 cycles, high 1, low 3 (bounce) -> no mode change, db stays 0, dbg stays 0.
REQ-031 Four clean presses on nPB[1] (each held 10 edges, released 10) -> modes FAST, ON (nLED[1]=0 steady), OFF (nLED[1]=1 steady), SLOW.
REQ-032 Both buttons pressed on the same edge -> both channels enter FAST on the same edge; dbg=1 from edge 7 until DEBOUNCE+3 edges after release.
REQ-033 nRst pulsed low while channel 0 in ON -> nLED=2'b11 asynchronously, channel 0 resumes in SLOW after release.

Source files
------------

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: per-channel pushbutton controlled LED blinker.
// Each channel debounces its button and steps a four-state mode machine on
// every accepted press; the mode selects how the channel's LED is driven.
//
// Mode FSM states (per channel):
//   state | meaning
//   SLOW  | LED follows the shared slow blink phase
//   FAST  | LED follows the shared fast blink phase
//   ON    | LED steadily lit
//   OFF   | LED steadily dark
// A press (debounced 0->1) advances SLOW -> FAST -> ON -> OFF -> SLOW.
module led_blink_ctrl #(
    parameter int CHANNELS  = 2,
    parameter int SLOW_HALF = 5000000,
    parameter int FAST_HALF = 500000,
    parameter int DEBOUNCE  = 100000,
    parameter int ALT_PHASE = 1
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic [CHANNELS-1:0] nPB,
    output logic [CHANNELS-1:0] nLED,
    output logic                dbg
);

    localparam int SLOW_W = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
    localparam int FAST_W = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE);

    localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_HALF - 1);
    localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_HALF - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        MODE_SLOW = 2'd0,
        MODE_FAST = 2'd1,
        MODE_ON   = 2'd2,
        MODE_OFF  = 2'd3
    } mode_e;

    logic [SLOW_W-1:0]   slow_cnt_q, slow_cnt_d;
    logic                slow_ph_q, slow_ph_d;
    logic [FAST_W-1:0]   fast_cnt_q, fast_cnt_d;
    logic                fast_ph_q, fast_ph_d;
    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CHANNELS-1:0] db_vec;
    logic [CHANNELS-1:0] nled_vec;
    logic                dbg_q, dbg_d;

    // Slow divider: count 0..SLOW_HALF-1, toggle phase on the wrap edge.
    always_comb begin
        slow_cnt_d = slow_cnt_q + SLOW_W'(1);
        slow_ph_d  = slow_ph_q;
        if (slow_cnt_q == SLOW_LAST) begin
            slow_cnt_d = '0;
            slow_ph_d  = ~slow_ph_q;
        end
    end

    // Slow divider registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            slow_cnt_q <= '0;
            slow_ph_q  <= 1'b0;
        end else begin
            slow_cnt_q <= slow_cnt_d;
            slow_ph_q  <= slow_ph_d;
        end
    end

    // Fast divider: same structure as the slow one with its own period.
    always_comb begin
        fast_cnt_d = fast_cnt_q + FAST_W'(1);
        fast_ph_d  = fast_ph_q;
        if (fast_cnt_q == FAST_LAST) begin
            fast_cnt_d = '0;
            fast_ph_d  = ~fast_ph_q;
        end
    end

    // Fast divider registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            fast_cnt_q <= '0;
            fast_ph_q  <= 1'b0;
        end else begin
            fast_cnt_q <= fast_cnt_d;
            fast_ph_q  <= fast_ph_d;
        end
    end

    // Two-flop synchronizer; buttons are inverted so 1 means pressed.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~nPB;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // Odd channels run in antiphase when ALT_PHASE is set.
        localparam bit ODD_CH = (ALT_PHASE != 0) && ((g % 2) == 1);

        logic [DB_W-1:0] cnt_q, cnt_d;
        logic            db_q, db_d;
        logic            db_prev_q;
        logic            press;
        mode_e           mode_q, mode_d;
        logic            lit;
        logic            nled_q, nled_d;

        // Debouncer: the sync value must disagree with db for DEBOUNCE
        // consecutive cycles before db follows; any agreement restarts.
        always_comb begin
            db_d  = db_q;
            cnt_d = '0;
            if (sync2_q[g] != db_q) begin
                if (cnt_q == DB_LAST) begin
                    db_d  = ~db_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
        end

        // Debouncer state and the delayed copy used for edge detection.
        always_ff @(posedge clk or negedge nRst) begin
            if (!nRst) begin
                cnt_q     <= '0;
                db_q      <= 1'b0;
                db_prev_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                db_q      <= db_d;
                db_prev_q <= db_q;
            end
        end

        // A press is the cycle in which db has just risen; releases are ignored.
        assign press = db_q & ~db_prev_q;

        // Mode FSM next state and LED lit decode.
        always_comb begin
            mode_d = mode_q;
            lit    = 1'b0;
            unique case (mode_q)
                MODE_SLOW: begin
                    lit = slow_ph_q ^ ODD_CH;
                    if (press) mode_d = MODE_FAST;
                end
                MODE_FAST: begin
                    lit = fast_ph_q ^ ODD_CH;
                    if (press) mode_d = MODE_ON;
                end
                MODE_ON: begin
                    lit = 1'b1;
                    if (press) mode_d = MODE_OFF;
                end
                MODE_OFF: begin
                    lit = 1'b0;
                    if (press) mode_d = MODE_SLOW;
                end
                default: begin
                    lit    = 1'b0;
                    mode_d = MODE_SLOW;
                end
            endcase
            nled_d = ~lit;
        end

        // Mode register and registered active-low LED drive.
        always_ff @(posedge clk or negedge nRst) begin
            if (!nRst) begin
                mode_q <= MODE_SLOW;
                nled_q <= 1'b1;
            end else begin
                mode_q <= mode_d;
                nled_q <= nled_d;
            end
        end

        assign db_vec[g]   = db_q;
        assign nled_vec[g] = nled_q;
    end

    assign dbg_d = |db_vec;

    // Debug flag: any channel currently holding a debounced press.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            dbg_q <= 1'b0;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    assign nLED = nled_vec;
    assign dbg  = dbg_q;

endmodule
